// File: rtl/zap_tlb_dm_array.sv
// Direct-mapped TLB entry array with a background invalidate-all sweep.
// Latency: a lookup returns its entry on o_rdata/o_rvalid one cycle after i_ren.
// Backpressure: none; while o_busy=1, refill writes are dropped and lookups return invalid.
//
// Ports:
//   i_clk, i_reset        - clock; synchronous active-high reset (starts a full sweep)
//   i_inv                 - invalidate-all pulse; starts or restarts the sweep at index 0
//   i_ren, i_raddr        - lookup strobe and virtual address
//   i_wen, i_wdata, i_waddr - refill strobe, payload and virtual address from the page walker
//   o_rdata, o_rvalid     - registered lookup payload and valid bit (held while i_ren=0)
//   o_busy                - high exactly while the sweep is running
//
// Optional feature: define ZAP_TLB_FWD_EN to forward a same-cycle, same-index
// refill into the lookup result. Without it the lookup sees the pre-write entry.
module zap_tlb_dm_array #(
  parameter int DEPTH     = 8,
  parameter int WDT       = 32,
  parameter int INDEX_LSB = 20
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_inv,
  input  logic           i_ren,
  input  logic [31:0]    i_raddr,
  input  logic           i_wen,
  input  logic [WDT-1:0] i_wdata,
  input  logic [31:0]    i_waddr,
  output logic [WDT-1:0] o_rdata,
  output logic           o_rvalid,
  output logic           o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;

  // Each word is {valid, payload}; contents are only made meaningful by the sweep.
  logic [WDT:0]    mem [DEPTH];

  logic [AW-1:0]   ridx;
  logic [AW-1:0]   widx;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [WDT:0]    mem_wword;
  logic [WDT:0]    rd_word;
  logic            rd_clear;

  logic [WDT-1:0]  rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  // Only the index field of each address is significant.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^{i_raddr, i_waddr};

  assign ridx = i_raddr[INDEX_LSB +: AW];
  assign widx = i_waddr[INDEX_LSB +: AW];

  // Next-state and RAM write selection. The sweep owns the write port; a
  // refill is only accepted in IDLE and loses to a simultaneous invalidate.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = widx;
    mem_wword = '0;
    case (state_q)
      IDLE: begin
        if (i_inv) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (i_wen) begin
          mem_we    = 1'b1;
          mem_waddr = widx;
          mem_wword = {1'b1, i_wdata};
        end
      end
      SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wword = '0;
        cnt_d     = cnt_q + 1'b1;
        if (i_inv) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM has no reset; a write coinciding with reset is discarded.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) begin
      mem[mem_waddr] <= mem_wword;
    end
  end

  // Lookup path. Validity is cleared while sweeping or on an invalidate so a
  // held result can never outlive the entry it came from.
  assign rd_clear = (state_q == SWEEP) || i_inv;

  always_comb begin
    rd_word = mem[ridx];
`ifdef ZAP_TLB_FWD_EN
    if (mem_we && (mem_waddr == ridx)) begin
      rd_word = mem_wword;
    end
`endif
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    if (i_ren) begin
      rdata_d  = rd_word[WDT-1:0];
      rvalid_d = rd_word[WDT] & ~rd_clear;
    end else if (rd_clear) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_busy   = (state_q == SWEEP);

endmodule

// File: doc/zap_tlb_dm_array.md
ZAP_TLB_DM_ARRAY -- requirements
Module: zap_tlb_dm_array

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, at least 2.
REQ-002 SHALL have parameter WDT, default 32, entry payload width in bits.
REQ-003 SHALL have parameter INDEX_LSB, default 20, lowest VA bit used as index.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_inv  input  1  invalidate-all request pulse.
REQ-007 SHALL have port i_ren  input  1  lookup request.
REQ-008 SHALL have port i_raddr  input  32  lookup virtual address.
REQ-009 SHALL have port i_wen  input  1  refill write strobe, from the page-walk FSM TLB write enable.
REQ-010 SHALL have port i_wdata  input  WDT  refill payload, from the page-walk FSM TLB write data.
REQ-011 SHALL have port i_waddr  input  32  refill virtual address, from the page-walk FSM held address.
REQ-012 SHALL have port o_rdata  output  WDT  lookup payload.
REQ-013 SHALL have port o_rvalid  output  1  lookup entry valid.
REQ-014 SHALL have port o_busy  output  1  invalidate sweep in progress.

Function
REQ-015 SHALL index entries with addr[INDEX_LSB +: log2(DEPTH)]; address bits outside this field SHALL be ignored.
REQ-016 SHALL store each entry as one RAM word {valid, payload}; the RAM SHALL have no reset.
REQ-017 SHALL implement two states, IDLE and SWEEP, plus a log2(DEPTH)-bit sweep counter.
REQ-018 In SWEEP, SHALL write {0, 0} to the entry at the counter index each cycle and increment the counter.
REQ-019 SHALL move from SWEEP to IDLE in the cycle after the counter writes index DEPTH-1, so a full sweep lasts exactly DEPTH cycles.
REQ-020 In IDLE, SHALL enter SWEEP with the counter at 0 on i_inv=1.
REQ-021 If i_inv=1 during SWEEP, SHALL restart the counter at 0.
REQ-022 SHALL drive o_busy=1 exactly while the state is SWEEP.
REQ-023 In IDLE, with i_wen=1 and i_inv=0, SHALL write {1, i_wdata} to the index of i_waddr.
REQ-024 SHALL drop i_wen when i_inv=1 or during SWEEP; i_inv takes priority.
REQ-025 With i_ren=1, SHALL register the addressed entry onto o_rdata/o_rvalid one cycle later.
REQ-026 With i_ren=0, o_rdata and o_rvalid SHALL hold their previous values.
REQ-027 SHALL force o_rvalid=0 in every cycle in which o_busy=1, and in the cycle after any i_inv=1.
REQ-028 If a read and a write hit the same index in the same cycle, the read result SHALL follow REQ-040/REQ-041.
REQ-029 Reads and writes to different indices in the same cycle SHALL be independent.

Reset
REQ-030 On i_reset=1, SHALL set state to SWEEP and the counter to 0.
REQ-031 On i_reset=1, SHALL set o_rdata=0 and o_rvalid=0.
REQ-032 After reset deasserts, o_busy SHALL read 1 for DEPTH cycles, then 0.
REQ-033 Reset asserted mid-sweep or mid-write SHALL restart the sweep from index 0 and discard any pending write.
REQ-034 Until the post-reset sweep completes, every lookup SHALL return o_rvalid=0.

Configuration
REQ-040 With macro ZAP_TLB_FWD_EN defined, a same-cycle, same-index read and write SHALL return o_rdata=i_wdata, o_rvalid=1 on the next cycle.
REQ-041 Without ZAP_TLB_FWD_EN, the same case SHALL return the entry as it was before the write; the new data SHALL be visible from the following read onward.

Verification
REQ-050 Reset, then poll o_busy (DEPTH=8) -> o_busy=1 for exactly 8 cycles; a read of 0x0010_0000 then gives o_rvalid=0.
REQ-051 Write 0x0030_0000 with data 0xA5A5_0C12, then read 0x0031_2345 next cycle -> o_rdata=0xA5A5_0C12, o_rvalid=1.
REQ-052 Same-cycle write and read of 0x0050_0000 with data 0x1234_5678 -> with macro: 0x1234_5678, valid=1; without: previous value.
REQ-053 Fill all 8 indices, pulse i_inv, read index 7 on sweep cycle 3 and after completion -> o_rvalid=0 both times; o_busy=1 for 8 cycles.
REQ-054 Pulse i_inv again on sweep cycle 5 -> counter restarts; o_busy stays high 8 more cycles (13 total).
REQ-055 Assert i_wen and i_inv together -> write dropped; the entry reads o_rvalid=0 after the sweep.
